// File: rtl/icap_stream_ctrl.sv
// icap_stream_ctrl: streams source words into the ICAP register block
// at address 0x00 and issues single readback triggers at 0x01.
module icap_stream_ctrl #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] word_count,
    input  logic                 rb_req,
    input  logic                 abort,
    input  logic                 s_valid,
    input  logic [BUS_WIDTH-1:0] s_data,
    output logic                 s_ready,
    output logic                 wready,
    output logic [7:0]           address,
    output logic [BUS_WIDTH-1:0] wrdata,
    input  logic                 icap_busy,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err_code,
    output logic [CNT_WIDTH-1:0] words_sent
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_TMO   = 2'b01;
    localparam logic [1:0] ERR_ABORT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_RB_ISSUE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           address_q, address_d;
    logic [BUS_WIDTH-1:0] wrdata_q, wrdata_d;
    logic [1:0]           err_q, err_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [TW-1:0]        tmo_q, tmo_d;

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        wrdata_d    = wrdata_q;
        err_d       = err_q;
        sent_d      = sent_q;
        remaining_d = remaining_q;
        tmo_d       = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (start) begin
                    sent_d = '0;
                    err_d  = ERR_NONE;
                    if (word_count != '0) begin
                        remaining_d = word_count;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (rb_req) begin
                    err_d     = ERR_NONE;
                    address_d = 8'h01;
                    wrdata_d  = '1;
                    state_d   = S_RB_ISSUE;
                end
            end
            S_FETCH: begin
                tmo_d = '0;
                if (s_valid) begin
                    wrdata_d  = s_data;
                    address_d = 8'h00;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!icap_busy) begin
                    sent_d      = sent_q + CNT_WIDTH'(1);
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    tmo_d       = '0;
                    state_d     = (remaining_q == CNT_WIDTH'(1)) ? S_DONE
                                                                 : S_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    err_d   = ERR_TMO;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RB_ISSUE: begin
                if (!icap_busy) begin
                    tmo_d   = '0;
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    err_d   = ERR_TMO;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort wins over everything but keeps a same-cycle accepted write counted
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            err_d   = ERR_ABORT;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            address_q   <= 8'h00;
            wrdata_q    <= '0;
            err_q       <= ERR_NONE;
            sent_q      <= '0;
            remaining_q <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            wrdata_q    <= wrdata_d;
            err_q       <= err_d;
            sent_q      <= sent_d;
            remaining_q <= remaining_d;
            tmo_q       <= tmo_d;
        end
    end

    assign s_ready    = (state_q == S_FETCH);
    assign wready     = (state_q == S_ISSUE) || (state_q == S_RB_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign address    = address_q;
    assign wrdata     = wrdata_q;
    assign err_code   = err_q;
    assign words_sent = sent_q;

endmodule

// File: tb/tb_icap_stream_ctrl.sv
// tb_icap_stream_ctrl: directed checks of icap_stream_ctrl with
// TIMEOUT=8, a posedge write monitor and a negedge source driver.
module tb_icap_stream_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [15:0] word_count;
    logic        rb_req;
    logic        abort;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        wready;
    logic [7:0]  address;
    logic [7:0]  wrdata;
    logic        icap_busy;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [15:0] words_sent;

    icap_stream_ctrl #(
        .BUS_WIDTH(8),
        .CNT_WIDTH(16),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .word_count(word_count),
        .rb_req(rb_req),
        .abort(abort),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .wready(wready),
        .address(address),
        .wrdata(wrdata),
        .icap_busy(icap_busy),
        .busy(busy),
        .done(done),
        .err_code(err_code),
        .words_sent(words_sent)
    );

    int tests = 0;
    int fails = 0;

    int         cyc = 0;
    int         n_acc = 0;
    int         n_done = 0;
    int         w_cyc = 0;
    int         b2_cyc = 0;
    int         fidx = 0;
    int         fbase = 0;
    logic [7:0] acc_addr [64];
    logic [7:0] acc_data [64];
    int         acc_cyc  [64];
    logic [7:0] pat [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wready) w_cyc <= w_cyc + 1;
        if (wready && wrdata == 8'hB2) b2_cyc <= b2_cyc + 1;
        if (wready && !icap_busy) begin
            acc_addr[n_acc & 63] <= address;
            acc_data[n_acc & 63] <= wrdata;
            acc_cyc[n_acc & 63]  <= cyc;
            n_acc <= n_acc + 1;
        end
        if (done) n_done <= n_done + 1;
        if (s_ready && s_valid) fidx <= fidx + 1;
    end

    initial begin
        s_data = 8'h00;
        forever begin
            @(negedge clk);
            s_data = pat[(fidx - fbase) & 7];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [15:0] wc);
        start      = 1'b1;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wait_acc(input string tag, input int target,
                            input bit need_wready);
        int k = 0;
        while (!(n_acc == target && (!need_wready || wready)) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, (k < 50), 1);
    endtask

    task automatic set_pat(input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3);
        for (int i = 0; i < 8; i++) pat[i] = 8'h00;
        pat[0] = p0;
        pat[1] = p1;
        pat[2] = p2;
        pat[3] = p3;
        fbase  = fidx;
    endtask

    int a0, d0, w0, b0;

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        word_count = '0;
        rb_req     = 1'b0;
        abort      = 1'b0;
        s_valid    = 1'b0;
        icap_busy  = 1'b0;
        set_pat(8'h00, 8'h00, 8'h00, 8'h00);
        step(2);

        chk("rst_busy", busy, 0);
        chk("rst_wready", wready, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_code, 0);
        chk("rst_ws", words_sent, 0);
        chk("rst_addr", address, 0);
        chk("rst_wrdata", wrdata, 0);
        rstn = 1'b1;
        step(1);

        // three words, no back-pressure
        set_pat(8'hA1, 8'hB2, 8'hC3, 8'h00);
        s_valid = 1'b1;
        a0 = n_acc;
        d0 = n_done;
        pulse_start(16'd3);
        chk("lat_c1_wready", wready, 0);
        step(1);
        chk("lat_c2_wready", wready, 1);
        chk("lat_c2_wrdata", wrdata, 8'hA1);
        wait_idle("a_idle", 40);
        chk("a_nacc", n_acc - a0, 3);
        chk("a_d0", acc_data[a0], 8'hA1);
        chk("a_d1", acc_data[a0 + 1], 8'hB2);
        chk("a_d2", acc_data[a0 + 2], 8'hC3);
        chk("a_addr", {acc_addr[a0], acc_addr[a0 + 1], acc_addr[a0 + 2]}, 0);
        chk("a_gap1", acc_cyc[a0 + 1] - acc_cyc[a0], 2);
        chk("a_gap2", acc_cyc[a0 + 2] - acc_cyc[a0 + 1], 2);
        chk("a_ws", words_sent, 3);
        chk("a_done", n_done - d0, 1);
        chk("a_err", err_code, 0);
        chk("a_done_low", done, 0);

        // busy for 5 cycles during word 2
        set_pat(8'hA1, 8'hB2, 8'hC3, 8'h00);
        a0 = n_acc;
        d0 = n_done;
        b0 = b2_cyc;
        pulse_start(16'd3);
        wait_acc("b_wait", a0 + 1, 1'b1);
        chk("b_w2_data", wrdata, 8'hB2);
        icap_busy = 1'b1;
        step(5);
        chk("b_hold_wready", wready, 1);
        chk("b_hold_data", wrdata, 8'hB2);
        icap_busy = 1'b0;
        wait_idle("b_idle", 40);
        chk("b_b2_cycles", b2_cyc - b0, 6);
        chk("b_nacc", n_acc - a0, 3);
        chk("b_d1", acc_data[a0 + 1], 8'hB2);
        chk("b_ws", words_sent, 3);
        chk("b_done", n_done - d0, 1);
        chk("b_err", err_code, 0);

        // timeout on word 2
        set_pat(8'h11, 8'h22, 8'h00, 8'h00);
        a0 = n_acc;
        d0 = n_done;
        pulse_start(16'd2);
        wait_acc("c_wait", a0 + 1, 1'b0);
        icap_busy = 1'b1;
        w0 = w_cyc;
        wait_idle("c_idle", 40);
        chk("c_busy_cycles", w_cyc - w0, 8);
        chk("c_wready", wready, 0);
        chk("c_err", err_code, 2'b01);
        chk("c_ws", words_sent, 1);
        chk("c_done", n_done - d0, 0);
        icap_busy = 1'b0;
        step(1);

        // readback trigger
        a0 = n_acc;
        d0 = n_done;
        rb_req = 1'b1;
        step(1);
        rb_req = 1'b0;
        chk("rb_addr_out", address, 8'h01);
        wait_idle("rb_idle", 20);
        chk("rb_nacc", n_acc - a0, 1);
        chk("rb_addr", acc_addr[a0], 8'h01);
        chk("rb_data", acc_data[a0], 8'hFF);
        chk("rb_done", n_done - d0, 1);
        chk("rb_ws", words_sent, 1);
        chk("rb_err", err_code, 0);

        // start and rb_req together: transfer only
        set_pat(8'h5A, 8'h00, 8'h00, 8'h00);
        a0 = n_acc;
        rb_req = 1'b1;
        pulse_start(16'd1);
        rb_req = 1'b0;
        wait_idle("sr_idle", 20);
        chk("sr_nacc", n_acc - a0, 1);
        chk("sr_addr", acc_addr[a0], 8'h00);
        chk("sr_data", acc_data[a0], 8'h5A);
        chk("sr_ws", words_sent, 1);

        // abort in FETCH of word 2 of 4
        set_pat(8'h11, 8'h22, 8'h33, 8'h44);
        a0 = n_acc;
        d0 = n_done;
        pulse_start(16'd4);
        wait_acc("e_wait", a0 + 1, 1'b0);
        chk("e_in_fetch", s_ready, 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("e_busy", busy, 0);
        chk("e_err", err_code, 2'b10);
        chk("e_ws", words_sent, 1);
        step(3);
        chk("e_nacc", n_acc - a0, 1);
        chk("e_done", n_done - d0, 0);

        // abort while idle is ignored
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("ia_err", err_code, 2'b10);
        chk("ia_busy", busy, 0);

        // zero-length transfer
        a0 = n_acc;
        d0 = n_done;
        pulse_start(16'd0);
        chk("z_done", done, 1);
        chk("z_wready", wready, 0);
        chk("z_err", err_code, 0);
        step(1);
        chk("z_done_low", done, 0);
        chk("z_busy", busy, 0);
        chk("z_ws", words_sent, 0);
        chk("z_nacc", n_acc - a0, 0);
        chk("z_ndone", n_done - d0, 1);

        // reset in ISSUE
        set_pat(8'hC5, 8'h00, 8'h00, 8'h00);
        icap_busy = 1'b1;
        d0 = n_done;
        a0 = n_acc;
        pulse_start(16'd2);
        wait_acc("r_wait", a0, 1'b1);
        chk("r_pre_data", wrdata, 8'hC5);
        #2 rstn = 1'b0;
        #1;
        chk("r_wready", wready, 0);
        chk("r_busy", busy, 0);
        chk("r_sready", s_ready, 0);
        chk("r_wrdata", wrdata, 0);
        chk("r_addr", address, 0);
        chk("r_err", err_code, 0);
        chk("r_ws", words_sent, 0);
        @(negedge clk);
        rstn      = 1'b1;
        icap_busy = 1'b0;
        step(3);
        chk("r_post_busy", busy, 0);
        chk("r_post_done", n_done - d0, 0);
        chk("r_post_nacc", n_acc - a0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
